dmem_readout: RTL and testbench
===============================

Name: dmem_readout

Overview:
- Read-back engine for the core's word-addressed data memory. It is the reader counterpart to memory preload.
- On `start`, it reads a contiguous block of words, e.g. the 50-word Keccak state at word 0. It streams them out over a valid/ready interface with word index and last flag.
- It sits beside `data_memory` on a secondary read port. It is used to dump results after the core finishes.

Parameters:
- ADDR_W, 10, data memory word-address width (1024 words).
- DATA_W, 32, word width.
- BASE_ADDR, 0, first word address read.
- WORD_COUNT, 50, number of words streamed per run (1..2^ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word handshake.
- mem_rd_en  out  1  read strobe to data memory.
- mem_addr  out  ADDR_W  word address for the read.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word this cycle.
- out_data  out  DATA_W  word value.
- out_index  out  ADDR_W  offset of the word from BASE_ADDR.
- out_last  out  1  high with the final word (index WORD_COUNT-1).
- checksum  out  DATA_W  XOR of all streamed words; see Optional Feature.

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=BASE_ADDR, out_valid=0, out_data=0, out_index=0, out_last=0, checksum=0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE→RUN on start. Issue counter and stream counter clear.
  - RUN→FLUSH once WORD_COUNT reads have been issued.
  - FLUSH→IDLE on the handshake of the last word. done pulses in the cycle after that handshake.
- Buffering:
  - 2-entry output FIFO, plus one in-flight read slot.
  - A read is issued (mem_rd_en=1) only when (fifo_count + inflight) < 2 and reads remain.
  - This guarantees no overflow under any out_ready pattern.
  - Returned data is written into the FIFO 1 cycle after issue.
- Throughput and latency:
  - Sustained 1 word/cycle with out_ready held high.
  - The first out_valid asserts 2 cycles after the start cycle: issue at T+1, data at T+2.
- Handshake:
  - The word transfers when out_valid && out_ready.
  - out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- Addressing:
  - mem_addr = BASE_ADDR + issue count, modulo 2^ADDR_W.
  - Wrap past the top address continues at 0. There is no error flag.
- Boundaries:
  - WORD_COUNT=1: the single word carries out_last=1.
  - out_ready held low: at most 2 reads are issued, then mem_rd_en stays 0 until space frees.
  - start while busy or in the done cycle: ignored.
  - start coincident with reset: reset wins.
  - Reset mid-run: aborts immediately. The FIFO is emptied and all outputs return to reset values. No done pulse.
  - Memory data returning after a reset is discarded.

Optional Feature:
- Macro: DMEM_READOUT_CHECKSUM_EN.
- Defined:
  - checksum clears on accepted start.
  - It XORs in out_data on every handshake.
  - The final value is valid from the done pulse and is held until the next start or reset.
- Undefined: checksum is constant 0 and no accumulator logic is built.

Test Plan:
- Preload mem[0]=997b5853, mem[1]=00000001, mem[33]=80000000, others 0; pulse start with out_ready=1 → 50 consecutive words.
  - First out_valid 2 cycles after start; index 0..49.
  - Word 33 = 80000000; out_last only on index 49.
  - done 1 cycle after the last handshake; checksum = 197b5852 with the macro, 0 without.
- Same preload, out_ready toggling 1010… and a random pattern → identical data/index sequence, no duplicates or drops.
  - Data is stable while stalled; mem_rd_en never issues with 2 words pending.
- out_ready=0 for 20 cycles after start → exactly 2 reads issued, out_valid=1 holding word 0.
  - On release, the stream completes correctly.
- BASE_ADDR=1022, WORD_COUNT=4 with mem[1022]=A, mem[1023]=B, mem[0]=C, mem[1]=D → stream A,B,C,D with wrapped addresses.
- Assert reset at word 10 of a run → next cycle all outputs are at reset values.
  - No done pulse; a subsequent start streams from index 0 correctly.
- start pulsed during a run, and WORD_COUNT=1 → the mid-run start is ignored.
  - The single-word run gives out_valid with out_last=1, then done.

Source files
------------

// File: rtl/dmem_readout.sv
// Streams WORD_COUNT words from data memory, starting at BASE_ADDR, over valid/ready with index/last.
// Optional XOR checksum of the streamed words: define DMEM_READOUT_CHECKSUM_EN.
module dmem_readout #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned WORD_COUNT = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);
    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORD_COUNT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_COUNT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]  issue_cnt;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_idx;
    logic [DATA_W-1:0] fifo_data [2];
    logic [ADDR_W-1:0] fifo_idx [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        fifo_count;

    logic              accept, issue, pop, push, fifo_pop, fifo_empty;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_idx;

    // An empty FIFO lets the returning read bypass straight to the output,
    // which gives the two-cycle start-to-valid latency and 1 word/cycle.
    always_comb begin
        fifo_empty = (fifo_count == 2'd0);
        accept     = start && (state == IDLE) && !done;
        issue      = (state == RUN) && (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
        head_data  = fifo_empty ? mem_rdata : fifo_data[rd_ptr];
        head_idx   = fifo_empty ? inflight_idx : fifo_idx[rd_ptr];
        out_valid  = !fifo_empty || inflight;
        out_data   = out_valid ? head_data : '0;
        out_index  = out_valid ? head_idx : '0;
        out_last   = out_valid && (head_idx == LAST_IDX);
        pop        = out_valid && out_ready;
        fifo_pop   = pop && !fifo_empty;
        push       = inflight && !(pop && fifo_empty);
        busy       = (state != IDLE);
        mem_rd_en  = issue;
        mem_addr   = BASE + issue_cnt[ADDR_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (issue && issue_cnt == LAST_CNT) state_nxt = FLUSH;
            FLUSH:   if (pop && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            done         <= 1'b0;
            issue_cnt    <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_count   <= 2'd0;
        end else begin
            state        <= state_nxt;
            done         <= (state == FLUSH) && pop && out_last;
            inflight     <= issue;
            inflight_idx <= issue_cnt[ADDR_W-1:0];
            if (accept)
                issue_cnt <= '0;
            else if (issue)
                issue_cnt <= issue_cnt + 1'b1;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (fifo_pop)
                rd_ptr <= ~rd_ptr;
            case ({push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_idx[wr_ptr]  <= inflight_idx;
        end
    end

`ifdef DMEM_READOUT_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk) begin
        if (reset || accept)
            csum <= '0;
        else if (pop)
            csum <= csum ^ out_data;
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_readout.sv
// Directed bench for dmem_readout: default 50-word dump, stalls, reset abort, wrap and single-word runs.
module tb_dmem_readout;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic a_start, a_busy, a_done, a_rd_en, a_valid, a_ready, a_last;
    logic [9:0] a_addr, a_index;
    logic [31:0] a_rdata, a_data, a_cs;
    logic b_start, b_busy, b_done, b_rd_en, b_valid, b_ready, b_last;
    logic [9:0] b_addr, b_index;
    logic [31:0] b_rdata, b_data, b_cs;
    logic c_start, c_busy, c_done, c_rd_en, c_valid, c_ready, c_last;
    logic [9:0] c_addr, c_index;
    logic [31:0] c_rdata, c_data, c_cs;

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_errors = 0;

`ifdef DMEM_READOUT_CHECKSUM_EN
    localparam logic [31:0] EXP_CS_A = 32'h197b5852;
    localparam logic [31:0] EXP_CS_C = 32'h997b5853;
`else
    localparam logic [31:0] EXP_CS_A = 32'h0;
    localparam logic [31:0] EXP_CS_C = 32'h0;
`endif

    dmem_readout u_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_rd_en(a_rd_en), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_index(a_index), .out_last(a_last), .checksum(a_cs)
    );

    dmem_readout #(.BASE_ADDR(1022), .WORD_COUNT(4)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_index(b_index), .out_last(b_last), .checksum(b_cs)
    );

    dmem_readout #(.WORD_COUNT(1)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .busy(c_busy), .done(c_done),
        .mem_rd_en(c_rd_en), .mem_addr(c_addr), .mem_rdata(c_rdata),
        .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data),
        .out_index(c_index), .out_last(c_last), .checksum(c_cs)
    );

    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= mem[a_addr];
        if (b_rd_en) b_rdata <= mem[b_addr];
        if (c_rd_en) c_rdata <= mem[c_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_a(input int i);
        case (i)
            0:       return 32'h997b5853;
            1:       return 32'h00000001;
            33:      return 32'h80000000;
            default: return 32'h0;
        endcase
    endfunction

    // Stream monitor for u_a: order, stall stability, read budget, done timing.
    int col_hs, col_rd, col_done;
    logic prev_stall, prev_last_hs, held_last;
    logic [31:0] held_data;
    logic [9:0] held_idx;

    always @(negedge clk) begin
        if (reset) begin
            col_hs = 0; col_rd = 0; col_done = 0;
            prev_stall = 1'b0; prev_last_hs = 1'b0;
        end else begin
            if (a_start && !a_busy && !a_done) begin
                col_hs = 0; col_rd = 0; col_done = 0;
            end
            if (prev_stall) begin
                check_eq("stall_valid", 32'(a_valid), 32'd1);
                check_eq("stall_data", a_data, held_data);
                check_eq("stall_index", 32'(a_index), 32'(held_idx));
                check_eq("stall_last", 32'(a_last), 32'(held_last));
            end
            if (prev_last_hs || a_done) begin
                check_eq("done_timing", 32'(a_done), 32'(prev_last_hs));
                if (a_done) begin
                    check_eq("checksum", a_cs, EXP_CS_A);
                    col_done++;
                end
            end
            if (a_rd_en) begin
                check_eq("rd_pending_lt2", 32'((col_rd - col_hs) < 2), 32'd1);
                check_eq("rd_addr", 32'(a_addr), 32'(col_rd % 1024));
                col_rd++;
            end
            if (a_valid && a_ready) begin
                check_eq("word_data", a_data, word_a(col_hs));
                check_eq("word_index", 32'(a_index), 32'(col_hs));
                check_eq("word_last", 32'(a_last), 32'(col_hs == 49));
                col_hs++;
            end
            prev_last_hs = a_valid && a_ready && a_last;
            prev_stall   = a_valid && !a_ready;
            held_data    = a_data;
            held_idx     = a_index;
            held_last    = a_last;
        end
    end

    // mode 0: ready high, 1: toggling, 2: random, 3: held low for 20 cycles
    task automatic run_a(input int mode);
        int cyc;
        @(posedge clk); #1;
        a_ready = (mode != 3);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        if (mode == 0) begin
            check_eq("t1_valid", 32'(a_valid), 32'd0);
            check_eq("t1_busy", 32'(a_busy), 32'd1);
            check_eq("t1_rd_en", 32'(a_rd_en), 32'd1);
            check_eq("t1_addr", 32'(a_addr), 32'd0);
        end
        cyc = 0;
        while (col_done == 0 && cyc < 600) begin
            a_start = (mode == 1 && cyc == 30);
            case (mode)
                0:       a_ready = 1'b1;
                1:       a_ready = cyc[0];
                2:       a_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (cyc == 20) begin
                        check_eq("hold_reads", 32'(col_rd), 32'd2);
                        check_eq("hold_valid", 32'(a_valid), 32'd1);
                        check_eq("hold_data", a_data, 32'h997b5853);
                        check_eq("hold_index", 32'(a_index), 32'd0);
                        check_eq("hold_rd_en", 32'(a_rd_en), 32'd0);
                    end
                    a_ready = (cyc >= 20);
                end
            endcase
            @(posedge clk); #1;
            cyc++;
            if (mode == 0 && cyc == 1) begin
                check_eq("t2_valid", 32'(a_valid), 32'd1);
                check_eq("t2_data", a_data, 32'h997b5853);
            end
        end
        a_start = 1'b0;
        check_eq("run_done_seen", 32'(col_done), 32'd1);
        check_eq("run_words", 32'(col_hs), 32'd50);
        check_eq("run_reads", 32'(col_rd), 32'd50);
    endtask

    task automatic reset_mid_run();
        int cyc;
        @(posedge clk); #1;
        a_ready = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 0;
        while (col_hs < 10 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("reached_word10", 32'(col_hs >= 10), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_done", 32'(a_done), 32'd0);
        check_eq("rst_rd_en", 32'(a_rd_en), 32'd0);
        check_eq("rst_addr", 32'(a_addr), 32'd0);
        check_eq("rst_valid", 32'(a_valid), 32'd0);
        check_eq("rst_data", a_data, 32'd0);
        check_eq("rst_index", 32'(a_index), 32'd0);
        check_eq("rst_last", 32'(a_last), 32'd0);
        check_eq("rst_checksum", a_cs, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check_eq("post_rst_done", 32'(a_done), 32'd0);
            check_eq("post_rst_valid", 32'(a_valid), 32'd0);
        end
    endtask

    task automatic run_single();
        @(posedge clk); #1;
        c_ready = 1'b1;
        c_start = 1'b1;
        @(posedge clk); #1;
        check_eq("c_busy", 32'(c_busy), 32'd1);
        check_eq("c_rd_en", 32'(c_rd_en), 32'd1);
        check_eq("c_valid_t1", 32'(c_valid), 32'd0);
        @(posedge clk); #1;
        c_start = 1'b0;
        check_eq("c_valid", 32'(c_valid), 32'd1);
        check_eq("c_last", 32'(c_last), 32'd1);
        check_eq("c_index", 32'(c_index), 32'd0);
        check_eq("c_data", c_data, 32'h997b5853);
        check_eq("c_no_reissue", 32'(c_rd_en), 32'd0);
        @(posedge clk); #1;
        check_eq("c_done", 32'(c_done), 32'd1);
        check_eq("c_valid_after", 32'(c_valid), 32'd0);
        check_eq("c_checksum", c_cs, EXP_CS_C);
        c_start = 1'b1;
        @(posedge clk); #1;
        c_start = 1'b0;
        check_eq("c_done_start_busy", 32'(c_busy), 32'd0);
        check_eq("c_done_start_done", 32'(c_done), 32'd0);
        check_eq("c_done_start_rd", 32'(c_rd_en), 32'd0);
        @(posedge clk); #1;
        check_eq("c_idle_valid", 32'(c_valid), 32'd0);
    endtask

    task automatic run_wrap();
        logic [9:0] exp_addr [4];
        logic [31:0] exp_data [4];
        int j, k, cyc;
        logic seen_done;
        exp_addr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        exp_data = '{32'hA0A00001, 32'hB0B00002, 32'hC0C00003, 32'hD0D00004};
        mem[1022] = 32'hA0A00001;
        mem[1023] = 32'hB0B00002;
        mem[0]    = 32'hC0C00003;
        mem[1]    = 32'hD0D00004;
        @(posedge clk); #1;
        b_ready = 1'b1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        j = 0; k = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 30) begin
            @(negedge clk);
            if (b_rd_en && k < 4) begin
                check_eq("b_addr", 32'(b_addr), 32'(exp_addr[k]));
                k++;
            end
            if (b_valid && b_ready && j < 4) begin
                check_eq("b_data", b_data, exp_data[j]);
                check_eq("b_index", 32'(b_index), 32'(j));
                check_eq("b_last", 32'(b_last), 32'(j == 3));
                j++;
            end
            if (b_done) seen_done = 1'b1;
            cyc++;
        end
        check_eq("b_words", 32'(j), 32'd4);
        check_eq("b_reads", 32'(k), 32'd4);
        check_eq("b_done_seen", 32'(seen_done), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = 32'h997b5853;
        mem[1]  = 32'h00000001;
        mem[33] = 32'h80000000;
        a_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("init_busy", 32'(a_busy), 32'd0);
        check_eq("init_done", 32'(a_done), 32'd0);
        check_eq("init_rd_en", 32'(a_rd_en), 32'd0);
        check_eq("init_addr", 32'(a_addr), 32'd0);
        check_eq("init_valid", 32'(a_valid), 32'd0);
        check_eq("init_data", a_data, 32'd0);
        check_eq("init_index", 32'(a_index), 32'd0);
        check_eq("init_last", 32'(a_last), 32'd0);
        check_eq("init_checksum", a_cs, 32'd0);
        check_eq("init_b_addr", 32'(b_addr), 32'd1022);
        a_start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("start_with_reset_ignored", 32'(a_busy), 32'd0);

        run_a(0);
        run_a(1);
        run_a(2);
        run_a(3);
        reset_mid_run();
        run_a(0);
        run_single();
        run_wrap();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
